parity_serializer: RTL and testbench

Parametrised, clocked successor to the 3-bit combinational odd-parity generator. Accepts a WIDTH-bit parallel word through a valid/ready handshake, then emits it serially LSB-first followed by one parity bit. Parity sense (odd or even) is selectable per word. The block sits between a parallel data source and a serial link/transmitter, which can apply backpressure. A frame counter reports how many complete frames have been transferred.

---
 rtl/parity_serializer.sv | 120 ++++++++++++
 tb/tb_parity_serializer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_serializer.sv
`default_nettype none
// ============================================================================
// Module   : parity_serializer
// Brief    : Valid/ready parallel-to-serial converter, LSB-first data followed
//            by a per-word selectable odd/even parity bit; counts frames.
// Revision : 1.0
// ============================================================================
module parity_serializer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             odd_mode,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             par_bit,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int                 c_BIT_W    = $clog2(WIDTH);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_PAR  = 2'd2
    } state_t;

    state_t             r_state_q,     w_state_d;
    logic [WIDTH-1:0]   r_shift_q,     w_shift_d;
    logic [c_BIT_W-1:0] r_bit_q,       w_bit_d;
    logic               r_par_q,       w_par_d;
    logic [CNT_W-1:0]   r_frame_cnt_q, w_frame_cnt_d;

    logic w_in_ready;
    logic w_accept;

    // A new word may enter while the parity beat leaves, giving gap-free frames.
    assign w_in_ready = !rst && ((r_state_q == S_IDLE) ||
                                 ((r_state_q == S_PAR) && ser_ready));
    assign w_accept   = in_valid && w_in_ready;

    always_comb begin
        w_state_d     = r_state_q;
        w_shift_d     = r_shift_q;
        w_bit_d       = r_bit_q;
        w_par_d       = r_par_q;
        w_frame_cnt_d = r_frame_cnt_q;

        case (r_state_q)
            S_IDLE: begin
            end
            S_DATA: begin
                if (ser_ready) begin
                    w_shift_d = {1'b0, r_shift_q[WIDTH-1:1]};
                    w_bit_d   = r_bit_q + c_BIT_W'(1);
                    if (r_bit_q == c_LAST_BIT) begin
                        w_state_d = S_PAR;
                    end
                end
            end
            S_PAR: begin
                if (ser_ready) begin
                    w_frame_cnt_d = r_frame_cnt_q + CNT_W'(1);
                    w_state_d     = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        // Accept can only happen in IDLE or in a transferring PAR beat.
        if (w_accept) begin
            w_shift_d = in_data;
            w_bit_d   = '0;
            w_par_d   = (^in_data) ^ odd_mode;
            w_state_d = S_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= S_IDLE;
            r_shift_q     <= '0;
            r_bit_q       <= '0;
            r_par_q       <= 1'b0;
            r_frame_cnt_q <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_shift_q     <= w_shift_d;
            r_bit_q       <= w_bit_d;
            r_par_q       <= w_par_d;
            r_frame_cnt_q <= w_frame_cnt_d;
        end
    end

    always_comb begin
        ser_valid = (r_state_q != S_IDLE);
        ser_last  = (r_state_q == S_PAR);
        ser_out   = 1'b0;
        if (r_state_q == S_DATA) begin
            ser_out = r_shift_q[0];
        end else if (r_state_q == S_PAR) begin
            ser_out = r_par_q;
        end
    end

    assign in_ready  = w_in_ready;
    assign par_bit   = r_par_q;
    assign frame_cnt = r_frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_parity_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_parity_serializer
// Brief    : Self-checking bench; queue-based frame model vs. parity_serializer.
// Revision : 1.0
// ============================================================================
module tb_parity_serializer;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             odd_mode;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_last;
    logic             par_bit;
    logic [CNT_W-1:0] frame_cnt;

    parity_serializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .odd_mode  (odd_mode),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .ser_last  (ser_last),
        .par_bit   (par_bit),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the pending serial beats of the current frame, in send order.
    bit q[$];
    bit log_q[$];
    int m_fcnt = 0;
    bit m_par  = 1'b0;
    bit m_acc  = 1'b0;
    bit chk_en = 1'b0;

    always @(posedge clk) begin
        bit rdy;
        bit p;
        m_acc = 1'b0;
        if (rst) begin
            q.delete();
            m_fcnt = 0;
            m_par  = 1'b0;
        end else begin
            rdy = (q.size() == 0) || (q.size() == 1 && ser_ready);
            if (ser_valid && ser_ready) log_q.push_back(ser_out);
            if (q.size() > 0 && ser_ready) begin
                if (q.size() == 1) m_fcnt = (m_fcnt + 1) % (1 << CNT_W);
                void'(q.pop_front());
            end
            if (in_valid && rdy) begin
                p = 1'b0;
                for (int b = 0; b < WIDTH; b++) begin
                    q.push_back(in_data[b]);
                    p ^= in_data[b];
                end
                p ^= odd_mode;
                q.push_back(p);
                m_par = p;
                m_acc = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ser_valid", 64'(ser_valid), 64'(q.size() != 0));
            check("ser_out",   64'(ser_out),   64'(q.size() != 0 ? q[0] : 1'b0));
            check("ser_last",  64'(ser_last),  64'(q.size() == 1));
            check("in_ready",  64'(in_ready),
                  64'(!rst && (q.size() == 0 || (q.size() == 1 && ser_ready))));
            check("par_bit",   64'(par_bit),   64'(m_par));
            check("frame_cnt", 64'(frame_cnt), 64'(m_fcnt));
        end
    end

    task automatic send(input logic [WIDTH-1:0] d, input logic odd);
        bit done;
        done     = 1'b0;
        in_data  = d;
        odd_mode = odd;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            #1;
            done = m_acc;
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 500 && q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (q.size() != 0) check("idle_timeout", 64'(q.size()), 64'd0);
    endtask

    task automatic log_check(input string name, input int n, input logic [63:0] exp);
        logic [63:0] got;
        got = '0;
        check({name, "_len"}, 64'(log_q.size()), 64'(n));
        for (int i = 0; i < n && i < log_q.size(); i++) got[i] = log_q[i];
        check(name, got, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired: got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit odd_tab [8];
        int fc0;
        odd_tab = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; odd_mode = 1'b0; ser_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("rst_ser_valid", 64'(ser_valid), 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Odd then even parity over words 0..7, odd_mode toggled mid-frame.
        for (int w = 0; w < 8; w++) begin
            send(WIDTH'(w), 1'b1);
            check("odd_par", 64'(par_bit), 64'(odd_tab[w]));
            odd_mode = ~odd_mode;
        end
        for (int w = 0; w < 8; w++) begin
            send(WIDTH'(w), 1'b0);
            check("even_par", 64'(par_bit), 64'(!odd_tab[w]));
            odd_mode = ~odd_mode;
        end
        wait_idle();

        // 8'hA5 under a 1,0,0 ready pattern.
        log_q.delete();
        send(8'hA5, 1'b1);
        for (int i = 0; i < 40; i++) begin
            ser_ready = (i % 3 == 0);
            @(posedge clk);
            #1;
        end
        ser_ready = 1'b1;
        log_check("a5_beats", 9, 64'h1A5);

        // Back-to-back 8'h01 then 8'hFF.
        wait_idle();
        fc0 = m_fcnt;
        send(8'h01, 1'b1);
        log_q.delete();
        in_data  = 8'hFF;
        in_valid = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(posedge clk);
            #1;
            if (m_acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        log_check("b2b_beats", 18, 64'h3FE01);
        check("b2b_frames", 64'(frame_cnt), 64'((fc0 + 2) % (1 << CNT_W)));
        check("b2b_idle",   64'(ser_valid), 64'd0);

        // Reset during the fourth data beat.
        send(8'h5A, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_ser_valid", 64'(ser_valid), 64'd0);
        check("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("midrst_in_ready",  64'(in_ready),  64'd0);
        rst = 1'b0;
        #1;
        check("midrst_in_ready_rel", 64'(in_ready), 64'd1);
        log_q.delete();
        send(8'h3C, 1'b0);
        wait_idle();
        log_check("after_rst_beats", 9, 64'h03C);

        // Counter wrap: 17 frames from reset.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 17; k++) begin
            send(WIDTH'($urandom), 1'($urandom));
            check("wrap_cnt", 64'(frame_cnt), 64'(k % 16));
        end
        wait_idle();
        check("wrap_final", 64'(frame_cnt), 64'd1);

        // Randomised traffic with backpressure and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            rst       = ($urandom_range(0, 99) == 0);
            in_valid  = 1'($urandom);
            in_data   = WIDTH'($urandom);
            odd_mode  = 1'($urandom);
            ser_ready = ($urandom_range(0, 3) != 0);
        end
        rst = 1'b0; in_valid = 1'b0; ser_ready = 1'b1;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
